// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute stage and its ALU.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alufun_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_e;

    typedef enum logic [1:0] {
        S_INS = 2'b00,
        S_ADR = 2'b01,
        S_HLT = 2'b10,
        S_AOK = 2'b11
    } status_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit Y86 ALU: valE = aluB op aluA, plus {ZF,SF,OF}.
module alu
    import y86_pkg::*;
(
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  logic [3:0]  alufun,
    output logic [63:0] valE,
    output cc_t         flags
);

    logic ovf;

    always_comb begin
        valE = '0;
        ovf  = 1'b0;
        case (alufun)
            ALU_ADD: begin
                valE = aluB + aluA;
                ovf  = (aluA[63] == aluB[63]) && (valE[63] != aluB[63]);
            end
            ALU_SUB: begin
                valE = aluB - aluA;
                ovf  = (aluA[63] != aluB[63]) && (valE[63] != aluB[63]);
            end
            ALU_AND: valE = aluB & aluA;
            ALU_XOR: valE = aluB ^ aluA;
            default: valE = '0;
        endcase
        flags.zf = (valE == '0);
        flags.sf = valE[63];
        flags.of = ovf;
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, CC register, branch/cmov
// condition and the memory pipeline register with bubble support.
module execute_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_destE,
    input  logic [3:0]  E_destM,
    input  logic [1:0]  E_status,
    input  logic [1:0]  m_status,
    input  logic [1:0]  W_status,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_destE,
    output logic        e_Cnd,
    output logic [3:0]  M_icode,
    output logic [1:0]  M_status,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_destE,
    output logic [3:0]  M_destM
);

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_fun;
    cc_t         alu_flags;
    cc_t         cc_d, cc_q;
    logic        set_cc;

    logic [3:0]  m_icode_d, m_icode_q;
    logic [1:0]  m_status_d, m_status_q;
    logic        m_cnd_d, m_cnd_q;
    logic [63:0] m_vale_d, m_vale_q;
    logic [63:0] m_vala_d, m_vala_q;
    logic [3:0]  m_deste_d, m_deste_q;
    logic [3:0]  m_destm_d, m_destm_q;

    always_comb begin
        case (E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:              alu_a = -64'sd8;
            I_RET, I_POPQ:                alu_a = 64'd8;
            default:                      alu_a = '0;
        endcase
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default:                                                   alu_b = '0;
        endcase
        alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;
    end

    alu u_alu (
        .aluA   (alu_a),
        .aluB   (alu_b),
        .alufun (alu_fun),
        .valE   (e_valE),
        .flags  (alu_flags)
    );

    // A non-AOK instruction anywhere downstream must not leave a CC side effect.
    always_comb begin
        set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR) &&
                 (E_status == S_AOK) && (m_status == S_AOK) && (W_status == S_AOK);
        cc_d   = set_cc ? alu_flags : cc_q;
    end

    // Condition uses the registered CC, never this cycle's ALU flags.
    always_comb begin
        case (E_ifun)
            C_ALWAYS: e_Cnd = 1'b1;
            C_LE:     e_Cnd = (cc_q.sf ^ cc_q.of) | cc_q.zf;
            C_L:      e_Cnd = cc_q.sf ^ cc_q.of;
            C_E:      e_Cnd = cc_q.zf;
            C_NE:     e_Cnd = ~cc_q.zf;
            C_GE:     e_Cnd = ~(cc_q.sf ^ cc_q.of);
            C_G:      e_Cnd = ~(cc_q.sf ^ cc_q.of) & ~cc_q.zf;
            default:  e_Cnd = 1'b0;
        endcase
        e_destE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : E_destE;
    end

    always_comb begin
        if (M_bubble) begin
            m_icode_d  = I_NOP;
            m_status_d = S_AOK;
            m_cnd_d    = 1'b0;
            m_vale_d   = '0;
            m_vala_d   = '0;
            m_deste_d  = REG_NONE;
            m_destm_d  = REG_NONE;
        end else begin
            m_icode_d  = E_icode;
            m_status_d = E_status;
            m_cnd_d    = e_Cnd;
            m_vale_d   = e_valE;
            m_vala_d   = E_valA;
            m_deste_d  = e_destE;
            m_destm_d  = E_destM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q       <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
            m_icode_q  <= I_NOP;
            m_status_q <= S_AOK;
            m_cnd_q    <= 1'b0;
            m_vale_q   <= '0;
            m_vala_q   <= '0;
            m_deste_q  <= REG_NONE;
            m_destm_q  <= REG_NONE;
        end else begin
            cc_q       <= cc_d;
            m_icode_q  <= m_icode_d;
            m_status_q <= m_status_d;
            m_cnd_q    <= m_cnd_d;
            m_vale_q   <= m_vale_d;
            m_vala_q   <= m_vala_d;
            m_deste_q  <= m_deste_d;
            m_destm_q  <= m_destm_d;
        end
    end

    assign M_icode  = m_icode_q;
    assign M_status = m_status_q;
    assign M_Cnd    = m_cnd_q;
    assign M_valE   = m_vale_q;
    assign M_valA   = m_vala_q;
    assign M_destE  = m_deste_q;
    assign M_destM  = m_destm_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_destE, E_destM;
    logic [1:0]  E_status, m_status, W_status;
    logic        M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_destE;
    logic        e_Cnd;
    logic [3:0]  M_icode;
    logic [1:0]  M_status;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [3:0]  M_destE, M_destM;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E_icode  (E_icode),
        .E_ifun   (E_ifun),
        .E_valC   (E_valC),
        .E_valA   (E_valA),
        .E_valB   (E_valB),
        .E_destE  (E_destE),
        .E_destM  (E_destM),
        .E_status (E_status),
        .m_status (m_status),
        .W_status (W_status),
        .M_bubble (M_bubble),
        .e_valE   (e_valE),
        .e_destE  (e_destE),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .M_status (M_status),
        .M_Cnd    (M_Cnd),
        .M_valE   (M_valE),
        .M_valA   (M_valA),
        .M_destE  (M_destE),
        .M_destM  (M_destM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                         input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
        E_icode = ic; E_ifun = fn; E_valC = vc; E_valA = va; E_valB = vb; E_destE = de;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; M_bubble = 1'b0;
        E_destM = 4'hF; E_status = 2'b11; m_status = 2'b11; W_status = 2'b11;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
        #12;
        chk("rst M_icode", M_icode, 64'h1);
        chk("rst M_destE", M_destE, 64'hF);
        chk("rst M_destM", M_destM, 64'hF);
        chk("rst M_status", M_status, 64'h3);
        chk("rst M_valE", M_valE, 64'h0);
        chk("rst CC", dut.cc_q, 64'h4);
        drive(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 4'hF);
        chk("rst jXX e", e_Cnd, 64'h1);
        drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF);
        chk("rst jXX l", e_Cnd, 64'h0);

        // Release reset away from an edge; the first edge must load normally.
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h6, 4'h0, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2);
        chk("add valE", e_valE, 64'h8000_0000_0000_0000);
        chk("add destE", e_destE, 64'h2);
        edge_step();
        chk("add M_valE", M_valE, 64'h8000_0000_0000_0000);
        chk("add M_icode", M_icode, 64'h6);
        chk("add M_valA", M_valA, 64'h1);
        chk("add M_destE", M_destE, 64'h2);
        chk("add CC", dut.cc_q, 64'h3);
        drive(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF);
        chk("ovf jXX l", e_Cnd, 64'h0);
        drive(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 4'hF);
        chk("ovf jXX g", e_Cnd, 64'h1);
        drive(4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
        chk("ovf jmp", e_Cnd, 64'h1);

        @(negedge clk);
        drive(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h1);
        chk("sub valE", e_valE, 64'h0);
        edge_step();
        chk("sub CC", dut.cc_q, 64'h4);
        drive(4'h2, 4'h4, 64'd0, 64'd7, 64'd0, 4'h3);
        chk("cmovne Cnd", e_Cnd, 64'h0);
        chk("cmovne destE", e_destE, 64'hF);
        edge_step();
        chk("cmovne M_destE", M_destE, 64'hF);
        chk("cmovne M_Cnd", M_Cnd, 64'h0);
        chk("cmovne M_valE", M_valE, 64'h7);
        drive(4'h2, 4'h3, 64'd0, 64'd7, 64'd0, 4'h3);
        chk("cmove destE", e_destE, 64'h3);

        @(negedge clk);
        drive(4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4);
        chk("push valE", e_valE, 64'hF8);
        edge_step();
        drive(4'hB, 4'h0, 64'd0, 64'd0, 64'hF8, 4'h4);
        chk("pop valE", e_valE, 64'h100);
        edge_step();
        chk("stack CC", dut.cc_q, 64'h4);

        m_status = 2'b10;
        drive(4'h6, 4'h3, 64'd0, 64'hF0, 64'hFF, 4'h5);
        chk("xor gated valE", e_valE, 64'h0F);
        edge_step();
        chk("xor gated CC", dut.cc_q, 64'h4);
        m_status = 2'b11; W_status = 2'b01;
        #1;
        edge_step();
        chk("W gated CC", dut.cc_q, 64'h4);
        W_status = 2'b11;
        #1;
        edge_step();
        chk("xor CC", dut.cc_q, 64'h0);
        drive(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 4'hF);
        chk("xor jne", e_Cnd, 64'h1);

        drive(4'h6, 4'h5, 64'd0, 64'd1, 64'd1, 4'h5);
        chk("bad ifun valE", e_valE, 64'h0);
        edge_step();
        chk("bad ifun CC", dut.cc_q, 64'h0);

        M_bubble = 1'b1;
        drive(4'h3, 4'h0, 64'd42, 64'd0, 64'd0, 4'h4);
        chk("irmov valE", e_valE, 64'd42);
        edge_step();
        chk("bub M_icode", M_icode, 64'h1);
        chk("bub M_valE", M_valE, 64'h0);
        chk("bub M_destE", M_destE, 64'hF);
        chk("bub M_status", M_status, 64'h3);
        M_bubble = 1'b0;
        #1;
        edge_step();
        chk("unbub M_valE", M_valE, 64'd42);
        chk("unbub M_icode", M_icode, 64'h3);
        chk("unbub M_destE", M_destE, 64'h4);

        M_bubble = 1'b1;
        drive(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h2);
        chk("sub neg valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        edge_step();
        chk("bub+opq CC", dut.cc_q, 64'h2);
        chk("bub+opq M_icode", M_icode, 64'h1);
        M_bubble = 1'b0;

        // Asynchronous reset between edges takes effect without a clock.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async M_icode", M_icode, 64'h1);
        chk("async CC", dut.cc_q, 64'h4);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h3, 4'h0, 64'd42, 64'd0, 64'd0, 4'h6);
        edge_step();
        chk("post-rst M_valE", M_valE, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
